// File: rtl/brc_pkg.sv
// Shared types for the chunked branch comparator: FSM state encoding and the
// result record carried from the compare datapath to the outputs.
package brc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } brc_state_t;

   typedef struct packed {
      logic less;
      logic equal;
   } brc_res_t;

endpackage

// File: rtl/brc_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice of the operands.
module brc_chunk
   import brc_pkg::*;
#(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             eq,
   output logic             lt
);

   assign eq = (a == b);
   assign lt = (a < b);

endmodule

// File: rtl/brc_seq.sv
// Multi-cycle branch comparator: walks the operands one chunk per cycle from
// the MSB end and stops at the first differing chunk.
module brc_seq
   import brc_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_valid,
   output logic                                o_ready,
   input  logic [WIDTH-1:0]                    i_rs1_data,
   input  logic [WIDTH-1:0]                    i_rs2_data,
   input  logic                                i_br_unsigned,
   output logic                                o_valid,
   input  logic                                i_ready,
   output logic                                o_br_less,
   output logic                                o_br_equal,
   output logic [$clog2(WIDTH/CHUNK+1)-1:0]    o_cycles
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned CYCW   = $clog2(NCHUNK + 1);
   localparam logic [IDXW-1:0] MSB_IDX = IDXW'(NCHUNK - 1);

   if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("brc_seq: WIDTH must be a nonzero integer multiple of CHUNK");
   end

   brc_state_t                     state;
   logic [NCHUNK-1:0][CHUNK-1:0]   rs1_q;
   logic [NCHUNK-1:0][CHUNK-1:0]   rs2_q;
   logic                           unsigned_q;
   logic [IDXW-1:0]                idx;
   logic [CYCW-1:0]                cycles;
   brc_res_t                       res;

   logic c_eq;
   logic c_lt;
   logic sign_diff;

   brc_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a  (rs1_q[idx]),
      .b  (rs2_q[idx]),
      .eq (c_eq),
      .lt (c_lt)
   );

   // Signed order only matters at the MSB chunk and only when the signs differ;
   // with equal signs the remaining bits order the same as unsigned.
   assign sign_diff = (idx == MSB_IDX) && !unsigned_q &&
                      (rs1_q[NCHUNK-1][CHUNK-1] != rs2_q[NCHUNK-1][CHUNK-1]);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         rs1_q      <= '0;
         rs2_q      <= '0;
         unsigned_q <= 1'b0;
         idx        <= '0;
         cycles     <= '0;
         res        <= '0;
         o_ready    <= 1'b1;
         o_valid    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid && o_ready) begin
                  rs1_q      <= i_rs1_data;
                  rs2_q      <= i_rs2_data;
                  unsigned_q <= i_br_unsigned;
                  idx        <= MSB_IDX;
                  cycles     <= '0;
                  res        <= '0;
                  o_ready    <= 1'b0;
                  state      <= CMP;
               end
            end
            CMP: begin
               cycles <= cycles + 1'b1;
               if (sign_diff) begin
                  res.less  <= rs1_q[NCHUNK-1][CHUNK-1];
                  res.equal <= 1'b0;
                  o_valid   <= 1'b1;
                  state     <= DONE;
               end else if (!c_eq) begin
                  res.less  <= c_lt;
                  res.equal <= 1'b0;
                  o_valid   <= 1'b1;
                  state     <= DONE;
               end else if (idx == '0) begin
                  res.less  <= 1'b0;
                  res.equal <= 1'b1;
                  o_valid   <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               o_valid <= 1'b0;
               o_ready <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign o_br_less  = res.less;
   assign o_br_equal = res.equal;
   assign o_cycles   = cycles;

endmodule

// File: tb/tb_brc_seq.sv
// Directed and randomised checks of brc_seq at three WIDTH/CHUNK settings.
module tb_brc_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        uns;
   logic        ack;

   always #5 clk = ~clk;

   // d0: 32/8, d1: 64/16, d2: 32/32
   logic        d0_ordy, d0_ovld, d0_less, d0_eq;
   logic [2:0]  d0_cyc;
   logic        d1_ordy, d1_ovld, d1_less, d1_eq;
   logic [2:0]  d1_cyc;
   logic        d2_ordy, d2_ovld, d2_less, d2_eq;
   logic [0:0]  d2_cyc;

   brc_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(req[0]), .o_ready(d0_ordy),
      .i_rs1_data(op_a[31:0]), .i_rs2_data(op_b[31:0]), .i_br_unsigned(uns),
      .o_valid(d0_ovld), .i_ready(ack), .o_br_less(d0_less), .o_br_equal(d0_eq),
      .o_cycles(d0_cyc)
   );

   brc_seq #(.WIDTH(64), .CHUNK(16)) u_dut64 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(req[1]), .o_ready(d1_ordy),
      .i_rs1_data(op_a), .i_rs2_data(op_b), .i_br_unsigned(uns),
      .o_valid(d1_ovld), .i_ready(ack), .o_br_less(d1_less), .o_br_equal(d1_eq),
      .o_cycles(d1_cyc)
   );

   brc_seq #(.WIDTH(32), .CHUNK(32)) u_dut32 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(req[2]), .o_ready(d2_ordy),
      .i_rs1_data(op_a[31:0]), .i_rs2_data(op_b[31:0]), .i_br_unsigned(uns),
      .o_valid(d2_ovld), .i_ready(ack), .o_br_less(d2_less), .o_br_equal(d2_eq),
      .o_cycles(d2_cyc)
   );

   int          sel;
   logic        s_valid, s_ordy, s_less, s_eq;
   int unsigned s_cyc;

   always_comb begin
      s_valid = d0_ovld; s_ordy = d0_ordy; s_less = d0_less; s_eq = d0_eq;
      s_cyc   = 32'(d0_cyc);
      case (sel)
         1: begin
            s_valid = d1_ovld; s_ordy = d1_ordy; s_less = d1_less; s_eq = d1_eq;
            s_cyc   = 32'(d1_cyc);
         end
         2: begin
            s_valid = d2_ovld; s_ordy = d2_ordy; s_less = d2_less; s_eq = d2_eq;
            s_cyc   = 32'(d2_cyc);
         end
         default: ;
      endcase
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int exp_k(input logic [63:0] a, input logic [63:0] b,
                                input int nch, input int ch);
      logic [63:0] m;
      m = (64'h1 << ch) - 64'h1;
      for (int c = nch - 1; c >= 0; c--) begin
         if (((a >> (c * ch)) & m) != ((b >> (c * ch)) & m)) return nch - c;
      end
      return nch;
   endfunction

   task automatic wait_valid(input string tag, output int m);
      m = 0;
      while (!s_valid && m < 20) begin
         @(negedge clk);
         m++;
      end
      if (!s_valid) chk({tag, " valid_timeout"}, 64'(s_valid), 64'd1);
   endtask

   // One full transaction; operands are scrambled right after acceptance.
   task automatic run_req(input int s, input logic [63:0] a, input logic [63:0] b,
                          input logic u, input logic lexp, input logic eexp,
                          input int kexp, input string tag);
      int m;
      sel = s;
      @(negedge clk);
      chk({tag, " ready"}, 64'(s_ordy), 64'd1);
      op_a = a; op_b = b; uns = u;
      req  = 3'(1 << s);
      @(negedge clk);
      req  = '0;
      op_a = ~a; op_b = ~b; uns = ~u;
      wait_valid(tag, m);
      chk({tag, " latency"}, 64'(m), 64'(kexp));
      chk({tag, " less"}, 64'(s_less), 64'(lexp));
      chk({tag, " equal"}, 64'(s_eq), 64'(eexp));
      chk({tag, " cycles"}, 64'(s_cyc), 64'(kexp));
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk({tag, " back_idle"}, 64'({s_valid, s_ordy}), 64'b01);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        u;
      logic        less;
      logic        equal;
      int          k;
   } vec_t;

   vec_t vecs[15];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] a, b;
      logic        u, le, ee;
      int          k, m;

      vecs[0]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 4};
      vecs[1]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1};
      vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1};
      vecs[3]  = '{32'h0000_0100, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 3};
      vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1};
      vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1};
      vecs[6]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 4};
      vecs[7]  = '{32'h1234_5678, 32'h1234_5679, 1'b1, 1'b1, 1'b0, 4};
      vecs[8]  = '{32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2};
      vecs[9]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1};
      vecs[10] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1};
      vecs[11] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 4};
      vecs[12] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 4};
      vecs[13] = '{32'h00FF_0000, 32'h00FE_0000, 1'b1, 1'b0, 1'b0, 2};
      vecs[14] = '{32'h0000_0080, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 4};

      sel = 0; rst_n = 1'b0; req = '0; op_a = '0; op_b = '0; uns = 1'b0; ack = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("reset state", 64'({d0_ordy, d0_ovld, d0_less, d0_eq, d0_cyc}), 64'b1000_000);

      foreach (vecs[i])
         run_req(0, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].u, vecs[i].less,
                 vecs[i].equal, vecs[i].k, $sformatf("vec%0d", i));

      // Result held under back-pressure while new requests are presented
      sel = 0;
      @(negedge clk);
      op_a = 64'h100; op_b = 64'h200; uns = 1'b1; req = 3'b001;
      @(negedge clk);
      req = '0;
      wait_valid("hold", m);
      for (int i = 0; i < 5; i++) begin
         op_a = 64'hFFFF_0000; op_b = 64'h1; uns = 1'b0; req = 3'b001;
         chk("hold valid_ready", 64'({s_valid, s_ordy}), 64'b10);
         chk("hold result", 64'({s_less, s_eq}), 64'b10);
         chk("hold cycles", 64'(s_cyc), 64'd3);
         @(negedge clk);
      end
      req = '0;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("hold release", 64'({s_valid, s_ordy}), 64'b01);
      repeat (6) @(negedge clk);
      chk("hold ignored req", 64'({s_valid, s_ordy}), 64'b01);

      // Reset in the middle of a 4-chunk compare
      @(negedge clk);
      op_a = 64'h5; op_b = 64'h5; uns = 1'b1; req = 3'b001;
      @(negedge clk);
      req = '0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_cmp state", 64'({d0_ordy, d0_ovld, d0_less, d0_eq, d0_cyc}), 64'b1000_000);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rst_cmp no result", 64'({d0_ovld, d0_ordy}), 64'b01);
      end

      // Reset while a result is waiting in DONE
      @(negedge clk);
      op_a = 64'h100; op_b = 64'h200; uns = 1'b1; req = 3'b001;
      @(negedge clk);
      req = '0;
      wait_valid("rst_done", m);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_done state", 64'({d0_ordy, d0_ovld, d0_less, d0_eq, d0_cyc}), 64'b1000_000);
      run_req(0, 64'h0000_0100, 64'h0000_0200, 1'b1, 1'b1, 1'b0, 3, "post_rst");

      // Random sweep on the 64/16 and 32/32 instances
      for (int s = 1; s <= 2; s++) begin
         for (int n = 0; n < 1000; n++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 2))
               0:       b = {$urandom, $urandom};
               1:       b = a;
               default: b = a ^ ({$urandom, $urandom} >> $urandom_range(0, 63));
            endcase
            u = 1'($urandom_range(0, 1));
            if (s == 1) begin
               le = u ? (a < b) : ($signed(a) < $signed(b));
               k  = exp_k(a, b, 4, 16);
            end else begin
               a[63:32] = '0;
               b[63:32] = '0;
               le = u ? (a < b) : ($signed(a[31:0]) < $signed(b[31:0]));
               k  = 1;
            end
            ee = (a == b);
            run_req(s, a, b, u, le, ee, k, $sformatf("rnd%0d_%0d", s, n));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
